// File: rtl/spike_group_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : spike_group_decoder
//  Description : Counts spikes per neuron over a fixed window and picks the
//                dominant neuron group. A (group, firing mask) decision has to
//                repeat over CONFIRM_CNT consecutive windows before it is
//                confirmed. Each newly confirmed decision is queued into a
//                valid/ready event FIFO.
//  Ports       : clk, rst_n (async, active-low), clear (sync soft clear)
//                spike_in    - one spike bit per neuron per cycle
//                win_strobe  - pulse in the COMPARE cycle
//                cur_valid/cur_group/cur_mask - last confirmed decision
//                ev_valid/ev_ready/ev_group/ev_mask - event FIFO head
//                fifo_full   - event FIFO holds FIFO_DEPTH entries
//                drop_cnt    - saturating dropped-event counter
//                              (only with SPIKE_DEC_DROP_CNT_EN defined)
//  Config      : `define SPIKE_DEC_DROP_CNT_EN adds the drop_cnt output.
//  Revision    : 1.0 - initial release
// ============================================================================
module spike_group_decoder #(
  parameter int NUM_NEURONS = 8,
  parameter int GROUP_SIZE  = 2,
  parameter int WINDOW_SIZE = 16,
  parameter int FIRE_THRESH = 4,
  parameter int CONFIRM_CNT = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         clear,
  input  logic [NUM_NEURONS-1:0]                       spike_in,
  output logic                                         win_strobe,
  output logic                                         cur_valid,
  output logic [$clog2(NUM_NEURONS/GROUP_SIZE)-1:0]    cur_group,
  output logic [GROUP_SIZE-1:0]                        cur_mask,
  output logic                                         ev_valid,
  input  logic                                         ev_ready,
  output logic [$clog2(NUM_NEURONS/GROUP_SIZE)-1:0]    ev_group,
  output logic [GROUP_SIZE-1:0]                        ev_mask,
`ifdef SPIKE_DEC_DROP_CNT_EN
  output logic [7:0]                                   drop_cnt,
`endif
  output logic                                         fifo_full
);

  localparam int c_num_groups = NUM_NEURONS / GROUP_SIZE;
  localparam int c_gw         = $clog2(c_num_groups);
  localparam int c_cnt_w      = $clog2(WINDOW_SIZE + 1);
  localparam int c_sum_w      = c_cnt_w + $clog2(GROUP_SIZE);
  localparam int c_win_w      = $clog2(WINDOW_SIZE);
  localparam int c_strk_w     = $clog2(CONFIRM_CNT + 1);
  localparam int c_ptr_w      = $clog2(FIFO_DEPTH);
  localparam int c_occ_w      = c_ptr_w + 1;

  typedef enum logic [0:0] {
    S_COUNT   = 1'b0,
    S_COMPARE = 1'b1
  } state_t;

  state_t                    r_state;
  logic [c_win_w-1:0]        r_win_cnt;
  logic [c_cnt_w-1:0]        r_cnt [NUM_NEURONS];
  logic [c_strk_w-1:0]       r_streak;
  logic [c_gw-1:0]           r_cand_group;
  logic [GROUP_SIZE-1:0]     r_cand_mask;
  logic                      r_cur_valid;
  logic [c_gw-1:0]           r_cur_group;
  logic [GROUP_SIZE-1:0]     r_cur_mask;

  logic [c_gw-1:0]           r_mem_group [FIFO_DEPTH];
  logic [GROUP_SIZE-1:0]     r_mem_mask  [FIFO_DEPTH];
  logic [c_ptr_w-1:0]        r_wr_ptr;
  logic [c_ptr_w-1:0]        r_rd_ptr;
  logic [c_occ_w-1:0]        r_occ;

  logic [c_sum_w-1:0]        w_sum   [c_num_groups];
  logic [GROUP_SIZE-1:0]     w_gmask [c_num_groups];
  logic [c_gw-1:0]           w_best;
  logic [c_sum_w-1:0]        w_best_sum;
  logic                      w_tie;
  logic [GROUP_SIZE-1:0]     w_dec_mask;
  logic                      w_dec_valid;
  logic                      w_do_compare;
  logic                      w_match;
  logic [c_strk_w-1:0]       w_streak_nxt;
  logic                      w_confirm;
  logic                      w_emit;
  logic                      w_full;
  logic                      w_pop;
  logic                      w_push;
  logic                      w_drop;

  // A clear in the COMPARE cycle suppresses the whole decision.
  assign w_do_compare = (r_state == S_COMPARE) && !clear;

  // Per-group sums and firing masks from the final window counts.
  always_comb begin
    for (int g = 0; g < c_num_groups; g++) begin
      w_sum[g]   = '0;
      w_gmask[g] = '0;
      for (int b = 0; b < GROUP_SIZE; b++) begin
        w_sum[g]      = w_sum[g] + c_sum_w'(r_cnt[g*GROUP_SIZE + b]);
        w_gmask[g][b] = (r_cnt[g*GROUP_SIZE + b] >= c_cnt_w'(FIRE_THRESH));
      end
    end
  end

  // Strictly-largest search; a later larger sum cancels an earlier tie.
  always_comb begin
    w_best     = '0;
    w_best_sum = w_sum[0];
    w_tie      = 1'b0;
    for (int g = 1; g < c_num_groups; g++) begin
      if (w_sum[g] > w_best_sum) begin
        w_best     = c_gw'(g);
        w_best_sum = w_sum[g];
        w_tie      = 1'b0;
      end else if (w_sum[g] == w_best_sum) begin
        w_tie = 1'b1;
      end
    end
    w_dec_mask  = w_gmask[w_best];
    w_dec_valid = !w_tie && (w_best_sum != '0) && (w_dec_mask != '0);
  end

  always_comb begin
    w_match = (r_cand_group == w_best) && (r_cand_mask == w_dec_mask);
    if (!w_match) begin
      w_streak_nxt = c_strk_w'(1);
    end else if (r_streak == c_strk_w'(CONFIRM_CNT)) begin
      w_streak_nxt = r_streak;
    end else begin
      w_streak_nxt = r_streak + c_strk_w'(1);
    end
    w_confirm = (w_streak_nxt == c_strk_w'(CONFIRM_CNT));
    w_emit    = w_do_compare && w_dec_valid && w_confirm &&
                (!r_cur_valid || (r_cur_group != w_best) || (r_cur_mask != w_dec_mask));
  end

  // Window FSM, spike counters and confirmation tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_COUNT;
      r_win_cnt    <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) r_cnt[i] <= '0;
      r_streak     <= '0;
      r_cand_group <= '0;
      r_cand_mask  <= '0;
      r_cur_valid  <= 1'b0;
      r_cur_group  <= '0;
      r_cur_mask   <= '0;
    end else if (clear) begin
      r_state      <= S_COUNT;
      r_win_cnt    <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) r_cnt[i] <= '0;
      r_streak     <= '0;
      r_cand_group <= '0;
      r_cand_mask  <= '0;
    end else begin
      case (r_state)
        S_COUNT: begin
          for (int i = 0; i < NUM_NEURONS; i++)
            r_cnt[i] <= r_cnt[i] + c_cnt_w'(spike_in[i]);
          if (r_win_cnt == c_win_w'(WINDOW_SIZE - 1)) begin
            r_win_cnt <= '0;
            r_state   <= S_COMPARE;
          end else begin
            r_win_cnt <= r_win_cnt + c_win_w'(1);
          end
        end
        default: begin
          for (int i = 0; i < NUM_NEURONS; i++) r_cnt[i] <= '0;
          if (w_dec_valid) begin
            r_cand_group <= w_best;
            r_cand_mask  <= w_dec_mask;
            r_streak     <= w_streak_nxt;
          end
          if (w_emit) begin
            r_cur_valid <= 1'b1;
            r_cur_group <= w_best;
            r_cur_mask  <= w_dec_mask;
          end
          r_state <= S_COUNT;
        end
      endcase
    end
  end

  // Event FIFO. When full, a push is only accepted alongside a pop; the
  // popped head slot is then rewritten as the new tail.
  assign w_full = (r_occ == c_occ_w'(FIFO_DEPTH));
  assign w_pop  = (r_occ != '0) && ev_ready;
  assign w_push = w_emit && (!w_full || w_pop);
  assign w_drop = w_emit && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_group[r_wr_ptr] <= w_best;
      r_mem_mask[r_wr_ptr]  <= w_dec_mask;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      if (w_push && !w_pop)      r_occ <= r_occ + c_occ_w'(1);
      else if (!w_push && w_pop) r_occ <= r_occ - c_occ_w'(1);
    end
  end

`ifdef SPIKE_DEC_DROP_CNT_EN
  logic [7:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != 8'hFF)) begin
      r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  assign drop_cnt = r_drop_cnt;
`else
  // Drops are silent in this build.
  logic w_unused_drop;
  assign w_unused_drop = w_drop;
`endif

  assign win_strobe = w_do_compare;
  assign cur_valid  = r_cur_valid;
  assign cur_group  = r_cur_group;
  assign cur_mask   = r_cur_mask;
  assign ev_valid   = (r_occ != '0);
  // Head storage is not reset; gate it so idle outputs read zero.
  assign ev_group   = ev_valid ? r_mem_group[r_rd_ptr] : '0;
  assign ev_mask    = ev_valid ? r_mem_mask[r_rd_ptr]  : '0;
  assign fifo_full  = w_full;

endmodule
`default_nettype wire

// File: tb/tb_spike_group_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spike_group_decoder
//  Description : Self-checking bench for spike_group_decoder (default
//                parameters, 17-cycle window). Window vectors are kept in a
//                table; FIFO overflow and clear cases are hand sequenced.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_group_decoder;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic [7:0] spike_in;
  logic       win_strobe;
  logic       cur_valid;
  logic [1:0] cur_group;
  logic [1:0] cur_mask;
  logic       ev_valid;
  logic       ev_ready;
  logic [1:0] ev_group;
  logic [1:0] ev_mask;
  logic       fifo_full;
`ifdef SPIKE_DEC_DROP_CNT_EN
  logic [7:0] drop_cnt;
`endif

  int n_tests;
  int n_fail;

  spike_group_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear),
    .spike_in   (spike_in),
    .win_strobe (win_strobe),
    .cur_valid  (cur_valid),
    .cur_group  (cur_group),
    .cur_mask   (cur_mask),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_group   (ev_group),
    .ev_mask    (ev_mask),
`ifdef SPIKE_DEC_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .fifo_full  (fifo_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One record per window: spikes pa for the first 3 COUNT cycles, pb for
  // the remaining 13, then the expected state seen the cycle after COMPARE.
  typedef struct {
    logic       rst;
    logic [7:0] pa;
    logic [7:0] pb;
    logic       cv;
    logic [1:0] grp;
    logic [1:0] msk;
    logic       evv;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Returns on the falling edge right after reset release; the next rising
  // edge is COUNT cycle 0.
  task automatic do_reset();
    rst_n    = 1'b0;
    clear    = 1'b0;
    spike_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called on the falling edge before COUNT cycle 0; returns on the falling
  // edge after the COMPARE cycle.
  task automatic do_window(input logic [7:0] pa, input logic [7:0] pb, input logic clr_cmp);
    for (int c = 0; c < 16; c++) begin
      spike_in = (c < 3) ? pa : pb;
      if (c == 0) check("strobe_idle", win_strobe, 0);
      @(negedge clk);
    end
    // COMPARE: spikes here must be ignored.
    clear    = clr_cmp;
    spike_in = 8'hFF;
    #1;
    check("strobe", win_strobe, !clr_cmp);
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic check_cur(input string name, input logic cv, input logic [1:0] g, input logic [1:0] m);
    check({name, "_cur"}, {cur_valid, cur_group, cur_mask}, {cv, g, m});
  endtask

  initial begin
    int pops;
    logic [1:0] exp_pop_grp [4];

    n_tests  = 0;
    n_fail   = 0;
    ev_ready = 1'b1;

    vecs[0]  = '{1'b1, 8'h03, 8'h03, 1'b0, 2'd0, 2'b00, 1'b0};
    vecs[1]  = '{1'b0, 8'h03, 8'h03, 1'b1, 2'd0, 2'b11, 1'b1};
    vecs[2]  = '{1'b0, 8'h03, 8'h03, 1'b1, 2'd0, 2'b11, 1'b0};
    vecs[3]  = '{1'b1, 8'h03, 8'h03, 1'b0, 2'd0, 2'b00, 1'b0};
    vecs[4]  = '{1'b0, 8'h0C, 8'h0C, 1'b0, 2'd0, 2'b00, 1'b0};
    vecs[5]  = '{1'b0, 8'h0C, 8'h0C, 1'b1, 2'd1, 2'b11, 1'b1};
    vecs[6]  = '{1'b0, 8'h11, 8'h11, 1'b1, 2'd1, 2'b11, 1'b0};
    vecs[7]  = '{1'b0, 8'h03, 8'h03, 1'b1, 2'd1, 2'b11, 1'b0};
    vecs[8]  = '{1'b0, 8'h11, 8'h11, 1'b1, 2'd1, 2'b11, 1'b0};
    vecs[9]  = '{1'b0, 8'h03, 8'h03, 1'b1, 2'd0, 2'b11, 1'b1};
    vecs[10] = '{1'b1, 8'h30, 8'h20, 1'b0, 2'd0, 2'b00, 1'b0};
    vecs[11] = '{1'b0, 8'h30, 8'h20, 1'b1, 2'd2, 2'b10, 1'b1};
    vecs[12] = '{1'b0, 8'h40, 8'h00, 1'b1, 2'd2, 2'b10, 1'b0};
    vecs[13] = '{1'b0, 8'h30, 8'h20, 1'b1, 2'd2, 2'b10, 1'b0};
    vecs[14] = '{1'b0, 8'h00, 8'h00, 1'b1, 2'd2, 2'b10, 1'b0};
    vecs[15] = '{1'b0, 8'hC0, 8'h40, 1'b1, 2'd2, 2'b10, 1'b0};
    vecs[16] = '{1'b0, 8'hC0, 8'h40, 1'b1, 2'd3, 2'b01, 1'b1};

    // Reset state: every output zero.
    do_reset();
    check("reset_outputs",
          {win_strobe, cur_valid, cur_group, cur_mask, ev_valid, ev_group, ev_mask, fifo_full},
          '0);

    // Table-driven windows (confirm, re-confirm, group change, ties, masks).
    for (int i = 0; i < 17; i++) begin
      if (vecs[i].rst) do_reset();
      do_window(vecs[i].pa, vecs[i].pb, 1'b0);
      check_cur($sformatf("vec%0d", i), vecs[i].cv, vecs[i].grp, vecs[i].msk);
      check($sformatf("vec%0d_ev_valid", i), ev_valid, vecs[i].evv);
      if (vecs[i].evv)
        check($sformatf("vec%0d_ev_data", i), {ev_group, ev_mask}, {vecs[i].grp, vecs[i].msk});
    end

    // FIFO overflow: six alternating events with the consumer stalled.
    do_reset();
    ev_ready = 1'b0;
    for (int e = 0; e < 6; e++) begin
      logic [7:0] pat;
      logic [1:0] g;
      pat = (e % 2 == 0) ? 8'h03 : 8'h0C;
      g   = (e % 2 == 0) ? 2'd0 : 2'd1;
      do_window(pat, pat, 1'b0);
      do_window(pat, pat, 1'b0);
      check_cur($sformatf("ovf_ev%0d", e + 1), 1'b1, g, 2'b11);
      check($sformatf("ovf_ev%0d_full", e + 1), fifo_full, (e >= 3));
      check($sformatf("ovf_ev%0d_head", e + 1), {ev_valid, ev_group, ev_mask}, {1'b1, 2'd0, 2'b11});
    end
`ifdef SPIKE_DEC_DROP_CNT_EN
    check("drop_cnt", drop_cnt, 8'd2);
`endif
    spike_in = '0;
    ev_ready = 1'b1;
    exp_pop_grp[0] = 2'd0;
    exp_pop_grp[1] = 2'd1;
    exp_pop_grp[2] = 2'd0;
    exp_pop_grp[3] = 2'd1;
    pops = 0;
    for (int c = 0; c < 8; c++) begin
      #1;
      if (ev_valid) begin
        if (pops < 4)
          check($sformatf("pop%0d", pops), {ev_group, ev_mask}, {exp_pop_grp[pops], 2'b11});
        pops++;
      end
      @(negedge clk);
    end
    check("pop_count", pops, 4);
    check("fifo_empty", {ev_valid, fifo_full}, 2'b00);

    // clear mid-window: the interrupted window and its streak are discarded.
    do_reset();
    do_window(8'h03, 8'h03, 1'b0);
    for (int c = 0; c < 8; c++) begin
      spike_in = 8'h03;
      @(negedge clk);
    end
    clear    = 1'b1;
    spike_in = 8'h03;
    @(negedge clk);
    clear = 1'b0;
    do_window(8'h03, 8'h03, 1'b0);
    check_cur("clr_mid_w1", 1'b0, 2'd0, 2'b00);
    check("clr_mid_w1_ev", ev_valid, 0);
    do_window(8'h03, 8'h03, 1'b0);
    check_cur("clr_mid_w2", 1'b1, 2'd0, 2'b11);
    check("clr_mid_w2_ev", {ev_valid, ev_group, ev_mask}, {1'b1, 2'd0, 2'b11});

    // clear in the COMPARE cycle: no strobe, no decision, streak zeroed.
    do_reset();
    do_window(8'h03, 8'h03, 1'b0);
    do_window(8'h03, 8'h03, 1'b1);
    check_cur("clr_cmp", 1'b0, 2'd0, 2'b00);
    check("clr_cmp_ev", ev_valid, 0);
    do_window(8'h03, 8'h03, 1'b0);
    check_cur("clr_cmp_next", 1'b0, 2'd0, 2'b00);
    do_window(8'h03, 8'h03, 1'b0);
    check_cur("clr_cmp_conf", 1'b1, 2'd0, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
